// File: rtl/bin2bcd_seq_pkg.sv
// Shared constants and state encoding for the sequential binary-to-BCD converter.
package bin2bcd_seq_pkg;

    localparam int BIN_W_DEF  = 7;
    localparam int DIGITS_DEF = 3;
    localparam int DIG_W      = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_e;

    // 10**n as a 64-bit constant, used only for the elaboration-time capacity check.
    function automatic longint unsigned pow10(input int n);
        longint unsigned r;
        r = 64'd1;
        for (int i = 0; i < n; i++) begin
            r = r * 64'd10;
        end
        return r;
    endfunction

endpackage

// File: rtl/bin2bcd_seq_bcd_digit_adj.sv
// Double-dabble digit correction: add 3 to a BCD digit that is 5 or more.
module bcd_digit_adj
    import bin2bcd_seq_pkg::*;
(
    input  logic [DIG_W-1:0] dig_i,
    output logic [DIG_W-1:0] dig_o
);

    // Inputs reaching here are at most 9, so the sum tops out at 12 and needs no carry.
    always_comb begin
        dig_o = dig_i;
        if (dig_i >= 4'd5) begin
            dig_o = dig_i + 4'd3;
        end
    end

endmodule

// File: rtl/bin2bcd_seq.sv
// Iterative binary-to-BCD converter, one input bit per clock, start/busy/done handshake.
module bin2bcd_seq
    import bin2bcd_seq_pkg::*;
#(
    parameter int BIN_W  = BIN_W_DEF,
    parameter int DIGITS = DIGITS_DEF
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    start_i,
    input  logic [BIN_W-1:0]        bin_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic [DIG_W*DIGITS-1:0] bcd_o
);

    localparam int SCR_W = DIG_W * DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam longint unsigned MAX_IN = (64'd1 << BIN_W) - 64'd1;

    // Reject parameter sets that cannot represent every input value.
    if (BIN_W < 1 || BIN_W > 16) begin : g_bad_width
        $error("bin2bcd_seq: BIN_W must be in 1..16");
    end
    if (pow10(DIGITS) <= MAX_IN) begin : g_bad_digits
        $error("bin2bcd_seq: DIGITS too small for BIN_W");
    end

    state_e             state_q, state_d;
    logic [BIN_W-1:0]   bin_q,   bin_d;
    logic [SCR_W-1:0]   scr_q,   scr_d;
    logic [SCR_W-1:0]   scr_adj;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic [SCR_W-1:0]   bcd_q,   bcd_d;
    logic               done_q,  done_d;

    // Per-digit add-3 correction applied before every shift.
    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .dig_i (scr_q[DIG_W*g +: DIG_W]),
            .dig_o (scr_adj[DIG_W*g +: DIG_W])
        );
    end

    // Next-state logic: capture in IDLE, adjust-and-shift in CONV, publish in DONE.
    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        scr_d   = scr_q;
        cnt_d   = cnt_q;
        bcd_d   = bcd_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    bin_d   = bin_i;
                    scr_d   = '0;
                    cnt_d   = CNT_W'(BIN_W);
                    state_d = CONV;
                end
            end
            CONV: begin
                // Binary MSB shifts into scratch bit 0.
                {scr_d, bin_d} = {scr_adj, bin_q} << 1;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                bcd_d   = scr_q;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any conversion in flight.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            bin_q   <= '0;
            scr_q   <= '0;
            cnt_q   <= '0;
            bcd_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            scr_q   <= scr_d;
            cnt_q   <= cnt_d;
            bcd_q   <= bcd_d;
            done_q  <= done_d;
        end
    end

    assign busy_o = (state_q != IDLE);
    assign done_o = done_q;
    assign bcd_o  = bcd_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed self-checking bench for bin2bcd_seq with default parameters.
module tb_bin2bcd_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic [6:0]  bin;
    logic        busy;
    logic        done;
    logic [11:0] bcd;

    int n_vec = 0;
    int n_err = 0;

    bin2bcd_seq #(.BIN_W(7), .DIGITS(3)) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .start_i (start),
        .bin_i   (bin),
        .busy_o  (busy),
        .done_o  (done),
        .bcd_o   (bcd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [11:0] ref_bcd(input int v);
        logic [3:0] h, t, u;
        h = 4'((v / 100) % 10);
        t = 4'((v / 10) % 10);
        u = 4'(v % 10);
        return {h, t, u};
    endfunction

    // One conversion: start for one cycle, optionally poke a second start at cycle
    // 'poke', then wait (bounded) for done. Returns edges from acceptance to done.
    task automatic run_conv(input logic [6:0] v, input logic [11:0] exp, input int poke,
                            input string tag);
        int          n;
        int          pulses;
        logic [11:0] prev;
        logic        stable;
        @(negedge clk);
        prev  = bcd;
        bin   = v;
        start = 1'b1;
        @(posedge clk);
        #1;
        chk({tag, "_busy_acc"}, 32'(busy), 32'd1);
        @(negedge clk);
        start  = 1'b0;
        n      = 0;
        pulses = 0;
        stable = 1'b1;
        while (n < 30) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (n == poke) begin
                start = 1'b1;
                bin   = 7'd100;
            end else if (poke != 0 && n == poke + 1) begin
                start = 1'b0;
            end
            if (poke == 0) bin = ~bin;
            if (done) begin
                pulses++;
                break;
            end
            if (bcd !== prev) stable = 1'b0;
        end
        chk({tag, "_lat"}, 32'(n), 32'd8);
        chk({tag, "_bcd"}, 32'(bcd), 32'(exp));
        chk({tag, "_busy_at_done"}, 32'(busy), 32'd0);
        chk({tag, "_stable"}, 32'(stable), 32'd1);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done) pulses++;
        end
        chk({tag, "_pulses"}, 32'(pulses), 32'd1);
        chk({tag, "_hold"}, 32'(bcd), 32'(exp));
    endtask

    initial begin
        int  n;
        int  last_edge;
        int  edge_cnt;
        bit  first;
        rst   = 1'b1;
        start = 1'b0;
        bin   = '0;
        #12;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_bcd",  32'(bcd),  32'd0);
        @(negedge clk);
        rst = 1'b0;

        run_conv(7'd42,  12'h042, 0, "c42");
        run_conv(7'd13,  12'h013, 0, "c13");
        run_conv(7'd0,   12'h000, 0, "c0");
        run_conv(7'd127, 12'h127, 0, "c127");
        run_conv(7'd99,  12'h099, 0, "c99");
        run_conv(7'd42,  12'h042, 3, "ign");

        // Reset in the middle of a conversion.
        @(negedge clk);
        bin   = 7'd85;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_done", 32'(done), 32'd0);
        chk("arst_bcd",  32'(bcd),  32'd0);
        @(negedge clk);
        rst = 1'b0;
        n = 0;
        repeat (12) begin
            @(negedge clk);
            if (done) n++;
        end
        chk("arst_no_done", 32'(n), 32'd0);
        run_conv(7'd85, 12'h085, 0, "c85");

        // Continuous start: sweep 0..127, spacing must be BIN_W+2 = 9 cycles.
        @(negedge clk);
        bin       = 7'd0;
        start     = 1'b1;
        first     = 1'b1;
        edge_cnt  = 0;
        last_edge = 0;
        for (int v = 0; v < 128; v++) begin
            n = 0;
            while (n < 30) begin
                @(posedge clk);
                edge_cnt++;
                n++;
                @(negedge clk);
                if (done) break;
            end
            chk("sw_timeout", 32'(n < 30), 32'd1);
            chk("sw_bcd", 32'(bcd), 32'(ref_bcd(v)));
            chk("sw_digits", 32'((bcd[3:0] <= 9) && (bcd[7:4] <= 9) && (bcd[11:8] <= 9)),
                32'd1);
            if (!first) chk("sw_spacing", 32'(edge_cnt - last_edge), 32'd9);
            first     = 1'b0;
            last_edge = edge_cnt;
            bin       = 7'(v + 1);
            if (v == 127) start = 1'b0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/bin2bcd_seq.md
Name: bin2bcd_seq

Overview:
- Sequential binary-to-BCD converter. It is the reverse path of the existing BCD-to-binary block.
- Uses iterative double-dabble (shift-and-add-3). Each conversion takes one bit per clock.
- Sits between binary datapath counters and the 7-segment display driver on the Elbert V2 board.
- Uses a start/busy/done handshake so the display side can request one conversion at a time.

Parameters:
- BIN_W, 7: width of the binary input. Valid range is 1 to 16.
- DIGITS, 3: number of BCD output digits. The output width is 4*DIGITS.
- Elaboration must fail if 10**DIGITS <= 2**BIN_W - 1, i.e. if DIGITS is too small to hold the largest input.

Ports:
- clk, input, 1: system clock. All state changes on its rising edge.
- rst, input, 1: asynchronous, active-high reset.
- start, input, 1: conversion request. Sampled only in IDLE.
- bin, input, BIN_W: unsigned binary value. Captured on the cycle start is accepted.
- busy, output, 1: high while a conversion is in progress.
- done, output, 1: single-cycle pulse when bcd has just been updated.
- bcd, output, 4*DIGITS: packed BCD result. Digit 0 (units) is in bits [3:0].

Behaviour:
- Reset (asynchronous, rst=1):
  - state=IDLE, busy=0, done=0, bcd=0.
  - The shift register and bit counter are cleared.
  - A reset asserted mid-conversion aborts it. No done pulse is produced and bcd reads 0.
- States: IDLE, CONV, DONE.
- IDLE:
  - If start=1 at a rising edge: capture bin into the shift register, clear the BCD scratch register, load count=BIN_W, go to CONV, and set busy=1.
  - If start=0, stay in IDLE.
- CONV, once per cycle:
  - Add 3 to every scratch digit that is >=5.
  - Then shift {scratch, binreg} left by 1, so the binary MSB enters scratch bit 0.
  - Decrement count. When count reaches 1 (this is the last shift), go to DONE.
- DONE:
  - Load bcd with the final scratch value, pulse done=1 for exactly one cycle, clear busy, and return to IDLE.
- Latency:
  - start accepted at edge k.
  - bcd valid and done=1 after edge k+BIN_W+1.
  - With the defaults this is 8 cycles from acceptance to done.
- start while busy (in CONV or DONE) is ignored and is not queued. bin changes during a conversion have no effect.
- Back-to-back operation: start=1 in the cycle done=1 is not accepted, because the FSM is still in DONE. It is accepted on the next IDLE edge. The minimum spacing between conversions is BIN_W+2 cycles.
- bcd holds its last result and changes only when moving DONE->IDLE. It is stable while busy=1.
- Width rules:
  - The scratch register is 4*DIGITS bits.
  - Digit adjust uses 4-bit adds with no carry out. The >=5 check guarantees the result is <=12, so it fits in 4 bits.
  - Every digit of bcd is always in 0 to 9.
- Inputs of 0 or all-ones need no special-case logic.

Decomposition:
- Shared package/header holds:
  - state encodings: IDLE=2'd0, CONV=2'd1, DONE=2'd2.
  - the default BIN_W and DIGITS constants.
  - the BCD digit width constant (4).
- One sub-module, bcd_digit_adj:
  - Combinational. Takes a 4-bit digit in and returns the digit plus 3 if it is >=5, otherwise unchanged.
  - Instantiated DIGITS times with a generate loop.
- The FSM, counter and shift register stay in the top level.

Test Plan:
- Reset, then start with bin=7'd42 -> done after 8 cycles, bcd=12'h042, busy low on the same cycle done rises.
- bin=7'd13 -> bcd=12'h013. Separately, bin=7'd0 -> bcd=12'h000 and done still pulses once.
- bin=7'd127 -> bcd=12'h127. Then bin=7'd99 -> bcd=12'h099, which checks that the add-3 adjust crosses digit boundaries.
- Start bin=7'd42, then at cycle 3 drive start=1 with bin=7'd100 -> that request is ignored. Result is still 12'h042 and only one done pulse occurs.
- Start bin=7'd85, assert rst at cycle 4 of CONV -> busy=0, done=0 and bcd=0 immediately (asynchronous). After release, start bin=7'd85 -> bcd=12'h085.
- Hold start=1 continuously, stepping bin through 0 to 127 -> each conversion is spaced BIN_W+2 cycles apart. Every result matches a reference decimal model and every digit is <=9.
